// File: rtl/store_ofmap_pkg.sv
// Shared definitions for store_ofmap: FSM state encodings, byte-lane geometry
// and the byte-offset to one-hot byte-enable decode.
package store_ofmap_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STORE = 1'b1
    } state_t;

    localparam int LANE_BYTES = 32 / 8;
    localparam int OFFSET_W   = $clog2(LANE_BYTES);

    function automatic logic [LANE_BYTES-1:0] wen_decode(input logic [OFFSET_W-1:0] offset);
        wen_decode = LANE_BYTES'(1) << offset;
    endfunction

endpackage

// File: rtl/store_ofmap_byte_lane_writer.sv
// One BRAM write port: registers word address, replicated byte and byte enable.
// STORE_OFMAP_RELU_EN clamps negative (signed) bytes to zero before the write.
module byte_lane_writer
    import store_ofmap_pkg::*;
#(
    parameter int BRAM_ADDR_BIT = 32,
    parameter int BRAM_WIDTH    = 32,
    parameter int DATA_WIDTH    = 8,
    parameter int BRAM_BYTE     = BRAM_WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     accept,
    input  logic [BRAM_ADDR_BIT-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    data,
    output logic [BRAM_ADDR_BIT-1:0] bram_addr,
    output logic [BRAM_WIDTH-1:0]    bram_din,
    output logic [BRAM_BYTE-1:0]     bram_wen
);

    logic [BRAM_ADDR_BIT-1:0] addr_p1;
    logic [BRAM_WIDTH-1:0]    din_p1;
    logic [BRAM_BYTE-1:0]     wen_p1;

    function automatic logic [DATA_WIDTH-1:0] relu(input logic signed [DATA_WIDTH-1:0] x);
`ifdef STORE_OFMAP_RELU_EN
        relu = (x < 0) ? '0 : x;
`else
        relu = x;
`endif
    endfunction

    // p1: write registered one cycle after accept; addr/din hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_p1 <= '0;
            din_p1  <= '0;
            wen_p1  <= '0;
        end else begin
            wen_p1 <= '0;
            if (accept) begin
                addr_p1 <= {addr[BRAM_ADDR_BIT-1:OFFSET_W], OFFSET_W'(0)};
                din_p1  <= {BRAM_BYTE{relu(data)}};
                wen_p1  <= BRAM_BYTE'(wen_decode(addr[OFFSET_W-1:0]));
            end
        end
    end

    assign bram_addr = addr_p1;
    assign bram_din  = din_p1;
    assign bram_wen  = wen_p1;

endmodule

// File: rtl/store_ofmap.sv
// Output feature-map store: four result bytes per cycle into four BRAMs,
// bursts of store_len over a circular buffer. Optional macro: STORE_OFMAP_RELU_EN.
module store_ofmap
    import store_ofmap_pkg::*;
#(
    parameter int BRAM_ADDR_BIT = 32,
    parameter int BRAM_WIDTH    = 32,
    parameter int DATA_WIDTH    = 8,
    parameter int BRAM_BYTE     = BRAM_WIDTH / 8,
    parameter int LEN_BIT       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     store_start,
    input  logic                     addr_rst,
    input  logic [LEN_BIT-1:0]       store_len,
    input  logic [BRAM_ADDR_BIT-1:0] ofmap_size,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [DATA_WIDTH-1:0]    data0,
    input  logic [DATA_WIDTH-1:0]    data1,
    input  logic [DATA_WIDTH-1:0]    data2,
    input  logic [DATA_WIDTH-1:0]    data3,
    output logic                     store_end,
    output logic                     ofmap_end,
    output logic                     BRAM_clk,
    output logic                     BRAM_rst,
    output logic                     BRAM_en,
    output logic [BRAM_ADDR_BIT-1:0] BRAM_0_addr,
    output logic [BRAM_ADDR_BIT-1:0] BRAM_1_addr,
    output logic [BRAM_ADDR_BIT-1:0] BRAM_2_addr,
    output logic [BRAM_ADDR_BIT-1:0] BRAM_3_addr,
    output logic [BRAM_WIDTH-1:0]    BRAM_0_din,
    output logic [BRAM_WIDTH-1:0]    BRAM_1_din,
    output logic [BRAM_WIDTH-1:0]    BRAM_2_din,
    output logic [BRAM_WIDTH-1:0]    BRAM_3_din,
    output logic [BRAM_BYTE-1:0]     BRAM_0_wen,
    output logic [BRAM_BYTE-1:0]     BRAM_1_wen,
    output logic [BRAM_BYTE-1:0]     BRAM_2_wen,
    output logic [BRAM_BYTE-1:0]     BRAM_3_wen
);

    state_t                   state;
    logic [LEN_BIT-1:0]       cnt;
    logic [BRAM_ADDR_BIT-1:0] addr_cur;
    logic                     accept;
    logic                     at_last;

    assign accept  = in_vld & in_rdy;
    assign at_last = (addr_cur == ofmap_size - BRAM_ADDR_BIT'(1));

    assign BRAM_clk = clk;
    assign BRAM_rst = 1'b0;

    // p1: control and pulse outputs line up with the registered BRAM write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr_cur  <= '0;
            in_rdy    <= 1'b0;
            store_end <= 1'b0;
            ofmap_end <= 1'b0;
            BRAM_en   <= 1'b0;
        end else begin
            store_end <= 1'b0;
            ofmap_end <= accept & at_last;
            BRAM_en   <= accept;

            // addr_rst wins over the advance; a concurrent write still uses addr_cur
            if (addr_rst)
                addr_cur <= '0;
            else if (accept)
                addr_cur <= at_last ? '0 : addr_cur + BRAM_ADDR_BIT'(1);

            case (state)
                ST_IDLE: begin
                    if (store_start) begin
                        if (store_len == '0) begin
                            store_end <= 1'b1;
                        end else begin
                            cnt    <= store_len;
                            state  <= ST_STORE;
                            in_rdy <= 1'b1;
                        end
                    end
                end
                ST_STORE: begin
                    if (accept) begin
                        cnt <= cnt - LEN_BIT'(1);
                        if (cnt == LEN_BIT'(1)) begin
                            store_end <= 1'b1;
                            state     <= ST_IDLE;
                            in_rdy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    in_rdy <= 1'b0;
                end
            endcase
        end
    end

    byte_lane_writer #(
        .BRAM_ADDR_BIT(BRAM_ADDR_BIT), .BRAM_WIDTH(BRAM_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .BRAM_BYTE(BRAM_BYTE)
    ) u_lane0 (
        .clk(clk), .rst(rst), .accept(accept), .addr(addr_cur), .data(data0),
        .bram_addr(BRAM_0_addr), .bram_din(BRAM_0_din), .bram_wen(BRAM_0_wen)
    );

    byte_lane_writer #(
        .BRAM_ADDR_BIT(BRAM_ADDR_BIT), .BRAM_WIDTH(BRAM_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .BRAM_BYTE(BRAM_BYTE)
    ) u_lane1 (
        .clk(clk), .rst(rst), .accept(accept), .addr(addr_cur), .data(data1),
        .bram_addr(BRAM_1_addr), .bram_din(BRAM_1_din), .bram_wen(BRAM_1_wen)
    );

    byte_lane_writer #(
        .BRAM_ADDR_BIT(BRAM_ADDR_BIT), .BRAM_WIDTH(BRAM_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .BRAM_BYTE(BRAM_BYTE)
    ) u_lane2 (
        .clk(clk), .rst(rst), .accept(accept), .addr(addr_cur), .data(data2),
        .bram_addr(BRAM_2_addr), .bram_din(BRAM_2_din), .bram_wen(BRAM_2_wen)
    );

    byte_lane_writer #(
        .BRAM_ADDR_BIT(BRAM_ADDR_BIT), .BRAM_WIDTH(BRAM_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .BRAM_BYTE(BRAM_BYTE)
    ) u_lane3 (
        .clk(clk), .rst(rst), .accept(accept), .addr(addr_cur), .data(data3),
        .bram_addr(BRAM_3_addr), .bram_din(BRAM_3_din), .bram_wen(BRAM_3_wen)
    );

endmodule

// File: tb/tb_store_ofmap.sv
// Directed bench for store_ofmap: bursts, stalls, wrap, addr_rst, zero length,
// async reset mid-burst and the optional STORE_OFMAP_RELU_EN clamp.
module tb_store_ofmap;

    logic        clk = 1'b0;
    logic        rst;
    logic        store_start;
    logic        addr_rst;
    logic [15:0] store_len;
    logic [31:0] ofmap_size;
    logic        in_vld;
    logic        in_rdy;
    logic [7:0]  data0, data1, data2, data3;
    logic        store_end, ofmap_end;
    logic        BRAM_clk, BRAM_rst, BRAM_en;
    logic [31:0] BRAM_0_addr, BRAM_1_addr, BRAM_2_addr, BRAM_3_addr;
    logic [31:0] BRAM_0_din, BRAM_1_din, BRAM_2_din, BRAM_3_din;
    logic [3:0]  BRAM_0_wen, BRAM_1_wen, BRAM_2_wen, BRAM_3_wen;

    int n_checks = 0;
    int n_fail   = 0;

    store_ofmap dut (
        .clk(clk), .rst(rst), .store_start(store_start), .addr_rst(addr_rst),
        .store_len(store_len), .ofmap_size(ofmap_size), .in_vld(in_vld), .in_rdy(in_rdy),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .store_end(store_end), .ofmap_end(ofmap_end),
        .BRAM_clk(BRAM_clk), .BRAM_rst(BRAM_rst), .BRAM_en(BRAM_en),
        .BRAM_0_addr(BRAM_0_addr), .BRAM_1_addr(BRAM_1_addr),
        .BRAM_2_addr(BRAM_2_addr), .BRAM_3_addr(BRAM_3_addr),
        .BRAM_0_din(BRAM_0_din), .BRAM_1_din(BRAM_1_din),
        .BRAM_2_din(BRAM_2_din), .BRAM_3_din(BRAM_3_din),
        .BRAM_0_wen(BRAM_0_wen), .BRAM_1_wen(BRAM_1_wen),
        .BRAM_2_wen(BRAM_2_wen), .BRAM_3_wen(BRAM_3_wen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Continuous burst; exp_byte lists the byte address each write must hit.
    task automatic run_burst(input string tag, input int len, input logic [7:0] d0,
                             input int exp_byte[8], input int arst_idx);
        logic [7:0] b;
        store_len   = 16'(len);
        store_start = 1'b1;
        tick();
        store_start = 1'b0;
        check({tag, "_rdy_on"}, in_rdy, 1);
        in_vld = 1'b1;
        for (int i = 0; i < len; i++) begin
            b        = d0 + 8'(i);
            data0    = b;
            data1    = b + 8'h10;
            data2    = b + 8'h20;
            data3    = b + 8'h30;
            addr_rst = (i == arst_idx);
            tick();
            addr_rst = 1'b0;
            check($sformatf("%s_en%0d", tag, i), BRAM_en, 1);
            check($sformatf("%s_addr0_%0d", tag, i), BRAM_0_addr, exp_byte[i] & ~3);
            check($sformatf("%s_addr3_%0d", tag, i), BRAM_3_addr, exp_byte[i] & ~3);
            check($sformatf("%s_wen0_%0d", tag, i), BRAM_0_wen, 4'b0001 << (exp_byte[i] & 3));
            check($sformatf("%s_wen2_%0d", tag, i), BRAM_2_wen, 4'b0001 << (exp_byte[i] & 3));
            check($sformatf("%s_din0_%0d", tag, i), BRAM_0_din, {4{b}});
            check($sformatf("%s_din3_%0d", tag, i), BRAM_3_din, {4{b + 8'h30}});
            check($sformatf("%s_send%0d", tag, i), store_end, i == len - 1);
            check($sformatf("%s_oend%0d", tag, i), ofmap_end, exp_byte[i] == int'(ofmap_size) - 1);
        end
        in_vld = 1'b0;
        check({tag, "_rdy_off"}, in_rdy, 0);
        tick();
        check({tag, "_en_after"}, BRAM_en, 0);
        check({tag, "_send_after"}, store_end, 0);
    endtask

    initial begin
        logic [6:0] pat;
        int         wr;
        rst = 1'b1; store_start = 1'b0; addr_rst = 1'b0; store_len = '0;
        ofmap_size = 32'd64; in_vld = 1'b0;
        data0 = '0; data1 = '0; data2 = '0; data3 = '0;
        repeat (2) tick();
        check("rst_en", BRAM_en, 0);
        check("rst_rdy", in_rdy, 0);
        check("rst_send", store_end, 0);
        check("rst_oend", ofmap_end, 0);
        check("rst_addr", BRAM_0_addr, 0);
        check("rst_wen", BRAM_0_wen, 0);
        check("rst_din", BRAM_1_din, 0);
        check("bram_rst", BRAM_rst, 0);
        check("bram_clk", BRAM_clk, clk);
        rst = 1'b0;
        tick();

        // in_vld while idle produces no write
        in_vld = 1'b1; data0 = 8'h55;
        tick();
        in_vld = 1'b0;
        tick();
        check("idle_vld_en", BRAM_en, 0);

        // Basic burst: bytes 0..5
        run_burst("basic", 6, 8'h11, '{0, 1, 2, 3, 4, 5, 0, 0}, -1);

        // Stalls: bytes 6..9, pattern 1,0,0,1,1,0,1 in time order
        pat = 7'b1011001;
        store_len = 16'd4; store_start = 1'b1;
        tick();
        store_start = 1'b0;
        wr = 0;
        for (int c = 0; c < 7; c++) begin
            in_vld = pat[c];
            data0  = 8'h40 + 8'(c);
            tick();
            check($sformatf("stall_en%0d", c), BRAM_en, pat[c]);
            if (pat[c]) begin
                check($sformatf("stall_addr%0d", wr), BRAM_0_addr, (6 + wr) & ~3);
                check($sformatf("stall_wen%0d", wr), BRAM_0_wen, 4'b0001 << ((6 + wr) & 3));
                check($sformatf("stall_din%0d", wr), BRAM_0_din, {4{8'h40 + 8'(c)}});
                wr++;
            end else begin
                check($sformatf("stall_wen_idle%0d", c), BRAM_0_wen, 0);
            end
            check($sformatf("stall_send%0d", c), store_end, c == 6);
        end
        in_vld = 1'b0;
        check("stall_writes", wr, 4);
        check("stall_rdy_off", in_rdy, 0);

        // Wrap with an 8-byte buffer
        ofmap_size = 32'd8;
        addr_rst = 1'b1;
        tick();
        addr_rst = 1'b0;
        check("arst_idle_en", BRAM_en, 0);
        check("arst_idle_oend", ofmap_end, 0);
        run_burst("wrap1", 6, 8'h01, '{0, 1, 2, 3, 4, 5, 0, 0}, -1);
        run_burst("wrap2", 6, 8'h21, '{6, 7, 0, 1, 2, 3, 0, 0}, -1);

        // addr_rst during the 3rd accept
        ofmap_size = 32'd64;
        addr_rst = 1'b1;
        tick();
        addr_rst = 1'b0;
        run_burst("arst", 6, 8'h31, '{0, 1, 2, 0, 1, 2, 0, 0}, 2);

        // Zero-length burst
        store_len = '0; store_start = 1'b1;
        tick();
        store_start = 1'b0;
        check("zero_send", store_end, 1);
        check("zero_en", BRAM_en, 0);
        check("zero_rdy", in_rdy, 0);
        tick();
        check("zero_send_after", store_end, 0);

        // Signed bytes, single-byte burst at byte 3
        store_len = 16'd1; store_start = 1'b1;
        tick();
        store_start = 1'b0;
        in_vld = 1'b1; data0 = 8'h85; data1 = 8'h7F;
        tick();
        in_vld = 1'b0;
        check("relu_en", BRAM_en, 1);
        check("relu_wen", BRAM_0_wen, 4'b1000);
`ifdef STORE_OFMAP_RELU_EN
        check("relu_din0", BRAM_0_din, 32'h00000000);
`else
        check("relu_din0", BRAM_0_din, 32'h85858585);
`endif
        check("relu_din1", BRAM_1_din, 32'h7F7F7F7F);
        check("relu_send", store_end, 1);
        tick();

        // Async reset mid-burst with cnt = 5
        store_len = 16'd8; store_start = 1'b1;
        tick();
        store_start = 1'b0;
        in_vld = 1'b1; data0 = 8'h66;
        repeat (3) tick();
        check("pre_rst_en", BRAM_en, 1);
        rst = 1'b1;
        #1;
        check("async_en", BRAM_en, 0);
        check("async_rdy", in_rdy, 0);
        check("async_din", BRAM_0_din, 0);
        check("async_wen", BRAM_0_wen, 0);
        check("async_addr", BRAM_0_addr, 0);
        in_vld = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        check("post_rst_rdy", in_rdy, 0);
        run_burst("post_rst", 1, 8'h51, '{0, 0, 0, 0, 0, 0, 0, 0}, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_ofmap.md
Name: store_ofmap

Overview:
- Write-side counterpart of the weight loader.
- Accepts one byte per output channel per cycle (4 channels) from the convolution datapath.
- Writes each byte into its channel's BRAM using byte-addressed, byte-enable writes on word-wide ports.
- Runs in bursts of store_len bytes per store_start; walks a circular output-feature-map buffer of ofmap_size bytes.

Parameters:
- BRAM_ADDR_BIT, 32, BRAM address width; byte address.
- BRAM_WIDTH, 32, BRAM data width.
- DATA_WIDTH, 8, result byte width; must equal 8.
- BRAM_BYTE, BRAM_WIDTH/8, number of byte enables per BRAM.
- LEN_BIT, 16, width of store_len.

Ports:
- clk  in  1  clock; BRAM_clk is driven from it.
- rst  in  1  reset, asynchronous, active-high.
- store_start  in  1  start one burst; sampled in IDLE only.
- addr_rst  in  1  synchronous; next write address becomes 0.
- store_len  in  LEN_BIT  bytes per channel in this burst; sampled with store_start.
- ofmap_size  in  BRAM_ADDR_BIT  buffer length in bytes; must be ≥1 and a multiple of 4.
- in_vld  in  1  data0..3 valid.
- in_rdy  out  1  block can accept data.
- data0, data1, data2, data3  in  DATA_WIDTH each  result byte for channel 0..3.
- store_end  out  1  one-cycle pulse: burst complete.
- ofmap_end  out  1  one-cycle pulse, coincident with the write of byte ofmap_size-1.
- BRAM_clk, BRAM_rst  out  1 each  BRAM_clk = clk; BRAM_rst = 0.
- BRAM_en  out  1  asserted on write cycles only.
- BRAM_k_addr  out  BRAM_ADDR_BIT  word-aligned address, k = 0..3.
- BRAM_k_din  out  BRAM_WIDTH  write data, k = 0..3.
- BRAM_k_wen  out  BRAM_BYTE  byte enables, k = 0..3.

Behaviour:
- Reset (rst high, async): FSM to IDLE; addr_cur = 0, cnt = 0. All outputs 0 except BRAM_clk.
- FSM states:
  - IDLE: in_rdy = 0.
  - STORE: in_rdy = 1.
- IDLE with store_start:
  - store_len == 0: stay IDLE, pulse store_end next cycle.
  - Otherwise: cnt = store_len, go to STORE.
- Accept = in_vld & in_rdy.
- On accept, next cycle (latency 1, all BRAM outputs registered):
  - BRAM_en = 1.
  - BRAM_k_addr = {addr_cur[BRAM_ADDR_BIT-1:2], 2'b00}.
  - BRAM_k_wen = 1 << addr_cur[1:0].
  - BRAM_k_din = datak replicated to all 4 byte lanes.
  - All four BRAMs share addr_cur.
- Non-accept cycle: BRAM_en and all wen = 0; addr and din hold their last values.
- After each accept:
  - addr_cur advances by 1.
  - If addr_cur == ofmap_size-1, it wraps to 0 and ofmap_end pulses alongside that write.
  - cnt decrements.
- Burst end: an accept with cnt == 1 returns the FSM to IDLE. store_end pulses in the same cycle as the final BRAM write.
- store_start in STORE: ignored.
- in_vld while in IDLE: ignored; no write.
- addr_rst: honoured in any state.
  - A concurrent accept writes at the current addr_cur.
  - The following write goes to address 0.
  - No ofmap_end is generated by addr_rst.
- in_vld may stall arbitrarily mid-burst; cnt and addr_cur hold while stalled.
- store_len and ofmap_size must be stable during a burst.

Optional Feature:
- STORE_OFMAP_RELU_EN defined: each datak is treated as signed. Negative values are written as 0x00; non-negative values pass unchanged. No added latency.
- Undefined: bytes are written verbatim.

Decomposition:
- Package store_ofmap_pkg holds:
  - FSM state encodings (ST_IDLE, ST_STORE).
  - Byte-lane constant (BRAM_BYTE derived).
  - Byte-enable decode function: offset → one-hot wen.
- Sub-module byte_lane_writer, instantiated ×4:
  - Takes the accept strobe, addr_cur and datak.
  - Registers addr, din and wen for one BRAM.
  - Contains the optional ReLU.
- The top level holds the FSM, cnt, addr_cur, wrap logic and the pulse outputs.

Test Plan:
1. Reset mid-burst: rst asserted with cnt = 5 → outputs 0 immediately (async); in_rdy = 0; next burst starts at address 0.
2. Basic burst, ofmap_size = 64, store_len = 6, data0 = 0x11..0x16, in_vld held high:
   - wen sequence 0001, 0010, 0100, 1000, 0001, 0010.
   - addr sequence 0, 0, 0, 0, 4, 4.
   - din = 0x11111111, ...
   - store_end on the 6th write; in_rdy drops the cycle after.
3. Stalls: store_len = 4, in_vld toggling 1,0,0,1,1,0,1 → exactly 4 writes; BRAM_en low on stall cycles; store_end with the 4th write.
4. Wrap: ofmap_size = 8, two bursts of store_len = 6 → second burst writes byte addrs 6, 7, 0, 1, 2, 3; ofmap_end pulses with the write to byte 7 (word addr 4, wen 1000).
5. addr_rst: asserted with the 3rd accept of a 6-byte burst → 3rd write at byte 2, 4th write at byte 0 (wen 0001); store_len = 0 start → store_end one cycle later, no BRAM_en.
6. STORE_OFMAP_RELU_EN defined, data0 = 0x85, data1 = 0x7F → din0 = 0x00000000, din1 = 0x7F7F7F7F; without the macro din0 = 0x85858585.
